// File: rtl/siso_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : siso_layer_scheduler
// Description : Layered-decoding read sequencer for one SISO row unit. It
//               sweeps row addresses for each layer and inserts gap cycles
//               between layers. After the last sweep it drains the row-unit
//               pipeline and then pulses done.
//               Optional macro EARLY_TERM_EN adds a syndrome_ok input. When
//               syndrome_ok is set, decoding stops after the current
//               iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module siso_layer_scheduler #(
    parameter int LAYERS     = 2,
    parameter int ADDRDEPTH  = 20,
    parameter int ADDRWIDTH  = 5,
    parameter int PIPESTAGES = 12,
    parameter int LAYER_GAP  = 2,
    parameter int ITERBITS   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ITERBITS-1:0]  max_iter,
`ifdef EARLY_TERM_EN
    input  logic                 syndrome_ok,
`endif
    output logic                 rdlayer,
    output logic [ADDRWIDTH-1:0] rdaddress,
    output logic                 rden_LLR,
    output logic                 rden_E,
    output logic [ITERBITS-1:0]  iter_count,
    output logic                 busy,
    output logic                 done
);

    localparam int c_gap_w   = (LAYER_GAP > 2) ? $clog2(LAYER_GAP) : 1;
    localparam int c_drain_w = (PIPESTAGES > 0) ? $clog2(PIPESTAGES + 1) : 1;

    localparam logic [ADDRWIDTH-1:0] c_addr_last  = ADDRWIDTH'(ADDRDEPTH - 1);
    localparam logic                 c_layer_last = 1'(LAYERS - 1);
    localparam logic [c_gap_w-1:0]   c_gap_last   =
        (LAYER_GAP > 0) ? c_gap_w'(LAYER_GAP - 1) : c_gap_w'(0);
    localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(PIPESTAGES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SWEEP = 3'd1,
        S_GAP   = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t                r_state, w_state;
    logic                  r_layer, w_layer;
    logic [ADDRWIDTH-1:0]  r_addr, w_addr;
    logic [ITERBITS-1:0]   r_iter, w_iter;
    logic [ITERBITS-1:0]   r_last_iter, w_last_iter;
    logic [c_gap_w-1:0]    r_gap_cnt, w_gap_cnt;
    logic [c_drain_w-1:0]  r_drain_cnt, w_drain_cnt;
    logic                  r_rden_llr, w_rden_llr;
    logic                  r_rden_e, w_rden_e;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;

    logic                  w_wrap;
    logic                  w_adv_layer;
    logic [ITERBITS-1:0]   w_adv_iter;
    logic                  w_early;

`ifdef EARLY_TERM_EN
    assign w_early = syndrome_ok;
`else
    assign w_early = 1'b0;
`endif

    // Layer and iteration values that apply once the current sweep ends.
    assign w_wrap      = (r_layer == c_layer_last);
    assign w_adv_layer = w_wrap ? 1'b0 : (r_layer + 1'b1);
    assign w_adv_iter  = w_wrap ? (r_iter + ITERBITS'(1)) : r_iter;

    always_comb begin
        w_state     = r_state;
        w_layer     = r_layer;
        w_addr      = r_addr;
        w_iter      = r_iter;
        w_last_iter = r_last_iter;
        w_gap_cnt   = r_gap_cnt;
        w_drain_cnt = r_drain_cnt;
        w_rden_llr  = 1'b0;
        w_rden_e    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;

        // Every w_* output value is the one shown while in w_state.
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state     = S_SWEEP;
                    w_layer     = 1'b0;
                    w_addr      = '0;
                    w_iter      = '0;
                    w_last_iter = (max_iter == '0) ? '0 : (max_iter - ITERBITS'(1));
                    w_rden_llr  = 1'b1;
                    w_busy      = 1'b1;
                end
            end

            S_SWEEP: begin
                w_busy = 1'b1;
                if (r_addr != c_addr_last) begin
                    w_addr     = r_addr + ADDRWIDTH'(1);
                    w_rden_llr = 1'b1;
                    w_rden_e   = (r_iter != '0);
                end else if (w_wrap && ((r_iter == r_last_iter) || w_early)) begin
                    w_state     = S_DRAIN;
                    w_addr      = '0;
                    w_drain_cnt = '0;
                end else begin
                    w_layer = w_adv_layer;
                    w_iter  = w_adv_iter;
                    w_addr  = '0;
                    if (LAYER_GAP > 0) begin
                        w_state   = S_GAP;
                        w_gap_cnt = '0;
                    end else begin
                        w_rden_llr = 1'b1;
                        w_rden_e   = (w_adv_iter != '0);
                    end
                end
            end

            S_GAP: begin
                w_busy = 1'b1;
                if (r_gap_cnt == c_gap_last) begin
                    w_state    = S_SWEEP;
                    w_rden_llr = 1'b1;
                    w_rden_e   = (r_iter != '0);
                end else begin
                    w_gap_cnt = r_gap_cnt + c_gap_w'(1);
                end
            end

            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_drain_cnt == c_drain_last) begin
                    w_state = S_FIN;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_drain_cnt = r_drain_cnt + c_drain_w'(1);
                end
            end

            S_FIN: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_layer     <= 1'b0;
            r_addr      <= '0;
            r_iter      <= '0;
            r_last_iter <= '0;
            r_gap_cnt   <= '0;
            r_drain_cnt <= '0;
            r_rden_llr  <= 1'b0;
            r_rden_e    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_layer     <= w_layer;
            r_addr      <= w_addr;
            r_iter      <= w_iter;
            r_last_iter <= w_last_iter;
            r_gap_cnt   <= w_gap_cnt;
            r_drain_cnt <= w_drain_cnt;
            r_rden_llr  <= w_rden_llr;
            r_rden_e    <= w_rden_e;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign rdlayer    = r_layer;
    assign rdaddress  = r_addr;
    assign rden_LLR   = r_rden_llr;
    assign rden_E     = r_rden_e;
    assign iter_count = r_iter;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_siso_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_siso_layer_scheduler
// Description : Two scheduler instances are compared cycle by cycle against a
//               trace model built from the sweep/gap/drain rules. Instance A
//               uses LAYER_GAP=1 and instance B uses LAYER_GAP=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_siso_layer_scheduler;

    localparam int LAY   = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int PIPE  = 3;
    localparam int IB    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_a = 1'b0, start_b = 1'b0;
    logic          syn_a = 1'b0, syn_b = 1'b0;
    logic [IB-1:0] max_iter = '0;

    logic          rdlayer_a, rden_llr_a, rden_e_a, busy_a, done_a;
    logic [AW-1:0] rdaddress_a;
    logic [IB-1:0] iter_a;
    logic          rdlayer_b, rden_llr_b, rden_e_b, busy_b, done_b;
    logic [AW-1:0] rdaddress_b;
    logic [IB-1:0] iter_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    siso_layer_scheduler #(.LAYERS(LAY), .ADDRDEPTH(DEPTH), .ADDRWIDTH(AW),
                           .PIPESTAGES(PIPE), .LAYER_GAP(1), .ITERBITS(IB)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .max_iter(max_iter),
`ifdef EARLY_TERM_EN
        .syndrome_ok(syn_a),
`endif
        .rdlayer(rdlayer_a), .rdaddress(rdaddress_a), .rden_LLR(rden_llr_a),
        .rden_E(rden_e_a), .iter_count(iter_a), .busy(busy_a), .done(done_a)
    );

    siso_layer_scheduler #(.LAYERS(LAY), .ADDRDEPTH(DEPTH), .ADDRWIDTH(AW),
                           .PIPESTAGES(PIPE), .LAYER_GAP(0), .ITERBITS(IB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .max_iter(max_iter),
`ifdef EARLY_TERM_EN
        .syndrome_ok(syn_b),
`endif
        .rdlayer(rdlayer_b), .rdaddress(rdaddress_b), .rden_LLR(rden_llr_b),
        .rden_E(rden_e_b), .iter_count(iter_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        bit llr, e, busy, done;
        bit chk_la, chk_ad, chk_it, synd_pt;
        int layer, addr, iter;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(bit llr, bit e, bit bsy, bit dn, bit cla, int la,
                                bit cad, int ad, bit cit, int it, bit sp);
        exp_t x;
        x.llr = llr; x.e = e; x.busy = bsy; x.done = dn;
        x.chk_la = cla; x.layer = la; x.chk_ad = cad; x.addr = ad;
        x.chk_it = cit; x.iter = it; x.synd_pt = sp;
        return x;
    endfunction

    // Expected output trace, cycle 1 = first sweep cycle, ending with FIN and one idle cycle.
    function automatic void build_model(input int m, input int gap, input int term_iter);
        int n;
        q.delete();
        n = (m == 0) ? 1 : m;
        if (term_iter >= 0 && term_iter < n - 1) n = term_iter + 1;
        for (int it = 0; it < n; it++) begin
            for (int la = 0; la < LAY; la++) begin
                for (int a = 0; a < DEPTH; a++)
                    q.push_back(mk(1, it != 0, 1, 0, 1, la, 1, a, 1, it,
                                   (la == LAY - 1) && (a == DEPTH - 1)));
                if (!(it == n - 1 && la == LAY - 1))
                    repeat (gap) q.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
            end
        end
        repeat (PIPE + 1) q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, n - 1, 0));
        q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, n - 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, n - 1, 0));
    endfunction

    task automatic run_decode(input int sel, input int m, input int term_iter,
                              input int restart_at, input int rst_at, output int done_cyc);
        logic          o_llr, o_e, o_busy, o_done, o_layer;
        logic [AW-1:0] o_addr;
        logic [IB-1:0] o_iter;
        exp_t          x;
        build_model(m, (sel == 0) ? 1 : 0, term_iter);
        done_cyc = -1;
        @(negedge clk);
        max_iter = IB'(m);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        for (int c = 1; c <= q.size(); c++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (sel == 0) begin
                o_llr = rden_llr_a; o_e = rden_e_a; o_busy = busy_a; o_done = done_a;
                o_layer = rdlayer_a; o_addr = rdaddress_a; o_iter = iter_a;
            end else begin
                o_llr = rden_llr_b; o_e = rden_e_b; o_busy = busy_b; o_done = done_b;
                o_layer = rdlayer_b; o_addr = rdaddress_b; o_iter = iter_b;
            end
            if (rst_at > 0 && c > rst_at)
                x = mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
            else
                x = q[c-1];
            chk("rden_LLR", 32'(o_llr), 32'(x.llr));
            chk("rden_E", 32'(o_e), 32'(x.e));
            chk("busy", 32'(o_busy), 32'(x.busy));
            chk("done", 32'(o_done), 32'(x.done));
            if (x.chk_la) chk("rdlayer", 32'(o_layer), 32'(x.layer));
            if (x.chk_ad) chk("rdaddress", 32'(o_addr), 32'(x.addr));
            if (x.chk_it) chk("iter_count", 32'(o_iter), 32'(x.iter));
            if (o_done === 1'b1 && done_cyc < 0) done_cyc = c;
            rst = (c == rst_at);
            if (c == restart_at) begin
                max_iter = IB'($urandom_range(0, 6));
                if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
            end
            if (q[c-1].synd_pt)
                syn_a = (q[c-1].iter == term_iter);
            else
                syn_a = 1'($urandom_range(0, 1));
            syn_b = syn_a;
        end
        rst = 1'b0;
        syn_a = 1'b0;
        syn_b = 1'b0;
    endtask

    initial begin
        int dc, sel, m, term, rs;
        repeat (3) @(negedge clk);
        chk("reset_rden_LLR", 32'(rden_llr_a), 0);
        chk("reset_rden_E", 32'(rden_e_a), 0);
        chk("reset_busy", 32'(busy_a), 0);
        chk("reset_done", 32'(done_a), 0);
        chk("reset_rdaddress", 32'(rdaddress_a), 0);
        chk("reset_rdlayer", 32'(rdlayer_a), 0);
        chk("reset_iter", 32'(iter_a), 0);
        chk("reset_b_busy", 32'(busy_b), 0);
        rst = 1'b0;

        run_decode(0, 2, -1, 0, 0, dc);
        chk("done_cycle_m2", dc, 24);
        run_decode(0, 0, -1, 0, 0, dc);
        chk("done_cycle_m0", dc, 14);
        run_decode(0, 2, -1, 5, 0, dc);
        chk("done_cycle_restart", dc, 24);
        run_decode(0, 2, -1, 0, 7, dc);
        chk("no_done_after_rst", dc, -1);
        run_decode(0, 2, -1, 0, 0, dc);
        chk("done_cycle_after_rst", dc, 24);
        run_decode(1, 1, -1, 0, 0, dc);
        chk("done_cycle_gap0", dc, 13);
`ifdef EARLY_TERM_EN
        run_decode(0, 4, 0, 0, 0, dc);
        chk("done_cycle_early", dc, 14);
`endif

        for (int k = 0; k < 16; k++) begin
            sel = int'($urandom_range(0, 1));
            m   = int'($urandom_range(0, 5));
`ifdef EARLY_TERM_EN
            term = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1;
`else
            term = -1;
`endif
            rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8)) : 0;
            run_decode(sel, m, term, rs, 0, dc);
            chk("done_cycle_rand", dc, q.size() - 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
